s38417_slot_bank_seq: RTL and testbench
=======================================

// Module: s38417_slot_bank_seq
// PURPOSE
// - Upstream feeder for the s38417 slot-compare cone: holds a 3-slot x WIDTH-bit register bank,
//   rotates a one-hot slot select, and presents the selected word plus select to the compare logic.
// - Also performs a registered compare of the selected word against an expected vector.
// - Keeps a saturating mismatch counter for diagnostics.
// PARAMETERS
// - WIDTH     10   bits per slot word; also the width of the expected vector
// - NSLOT     3    number of slots; fixed at 3, with a one-hot select of width 3
// - CNT_W     8    mismatch counter width
// PORTS
// - clk          in   1        single clock, rising edge
// - rst_n        in   1        synchronous reset, active low
// - wr_en        in   1        write strobe for the slot bank
// - wr_slot      in   2        target slot: 0..2 are valid; 3 is illegal
// - wr_data      in   WIDTH    write data
// - advance      in   1        rotate the select to the next slot
// - exp_valid    in   1        exp_vec is valid this cycle
// - exp_vec      in   WIDTH    expected word for the compare
// - cnt_clr      in   1        clear mismatch_cnt
// - sel_oh       out  3        one-hot slot select: bit0=slot0, bit1=slot1, bit2=slot2
// - sel_word     out  WIDTH    registered word of the selected slot
// - sel_valid    out  1        sel_word is valid
// - mismatch     out  1        registered compare result
// - mismatch_cnt out  CNT_W    saturating count of mismatches
// - wr_err       out  1        sticky flag: a write to wr_slot==3 was attempted
// BEHAVIOUR
// - Reset (rst_n==0 at a clk edge):
//   - bank cleared to 0; sel_oh=3'b001; sel_word=0; sel_valid=0.
//   - mismatch=0; mismatch_cnt=0; wr_err=0.
// - Select rotator: 3-state one-hot FSM S0(001) -> S1(010) -> S2(100) -> S0.
//   - Moves one step per cycle while advance==1; holds otherwise.
//   - sel_oh is always exactly one-hot; any other value is unreachable.
//   - A non-one-hot value seen by the assertion is a design error.
// - Bank write:
//   - wr_en with wr_slot in 0..2 updates that slot at the edge.
//   - wr_slot==3: no bank change; wr_err set. wr_err clears only on reset.
// - Word output: sel_word(t+1) = bank_next[sel_oh_next].
//   - Write-first, one cycle of latency: the update uses the post-edge select and post-edge bank contents.
//   - Simultaneous write and advance: the next word reflects the new slot, including the write if it targets that slot.
// - sel_valid: goes to 1 on the first cycle after reset release and stays at 1.
// - Compare:
//   - When exp_valid and sel_valid are both 1: mismatch(t+1) = |(sel_word ^ exp_vec), both sampled at t.
//   - Otherwise mismatch(t+1) = 0.
// - Counter: mismatch_cnt increments on each cycle where mismatch==1 and saturates at 2^CNT_W-1.
//   - cnt_clr has priority over an increment in the same cycle.
// - A reset in mid-rotation returns the block to S0 at once. No pending write survives the reset.
// STRUCTURE
// - Shared package s38417_pkg: slot index type, select constants SEL_S0/S1/S2, and the illegal slot constant SLOT_BAD=2'd3.
// - One sub-module, s38417_onehot_rot: the 3-state rotator (clk, rst_n, advance -> sel_oh, sel_oh_next).
// - Bank, output mux, compare and counter are in the top level. The mux is an AND-OR over the one-hot select.
// TESTING
// - Reset behaviour: hold rst_n=0 for 2 cycles -> sel_oh=001, sel_word=0, mismatch_cnt=0, wr_err=0.
// - Rotation: write slots 0,1,2 = 10'h155, 10'h2AA, 10'h3FF, then pulse advance 3 times.
//   - Required: sel_word = 155, 2AA, 3FF, then 155 again.
//   - Required: sel_oh = 001, 010, 100, 001.
// - Write and advance in the same cycle: in S0, advance=1 with a write of 10'h0F0 to slot1 -> next cycle sel_oh=010 and sel_word=0F0.
// - Compare: slot0 holds 155; exp_vec=155 -> mismatch=0.
//   - Then exp_vec=154 -> mismatch=1 and mismatch_cnt=1.
//   - Then exp_valid=0 -> mismatch=0.
// - Counter limits: force 300 mismatches -> mismatch_cnt=255 and holds there.
//   - cnt_clr together with a mismatch -> 0.
// - Illegal slot and mid-run reset: a write with wr_slot=3 -> bank unchanged and wr_err=1.
//   - Then rst_n=0 while in S2 -> S0, wr_err=0.

Source files
------------

// File: rtl/s38417_pkg.sv
// Shared types and constants for the s38417 slot-bank feeder.
// Slot index type, one-hot select encodings and the rotator state type.
package s38417_pkg;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_BAD = 2'd3;

    localparam logic [2:0] SEL_S0 = 3'b001;
    localparam logic [2:0] SEL_S1 = 3'b010;
    localparam logic [2:0] SEL_S2 = 3'b100;

    // State encoding is the select itself, so sel_oh needs no decode.
    typedef enum logic [2:0] {
        S0 = SEL_S0,
        S1 = SEL_S1,
        S2 = SEL_S2
    } rot_state_t;

endpackage

// File: rtl/s38417_onehot_rot.sv
// Three-state one-hot select rotator: S0 -> S1 -> S2 -> S0, one step per advance.
// Exposes both the current select and the select that will be live after the next edge.
module s38417_onehot_rot
    import s38417_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    output logic [2:0] sel_oh,
    output logic [2:0] sel_oh_next
);

    rot_state_t state;
    rot_state_t state_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (advance) begin
            unique case (state)
                S0:      state_nxt = S1;
                S1:      state_nxt = S2;
                S2:      state_nxt = S0;
                default: state_nxt = S0;
            endcase
        end
    end

    assign sel_oh      = state;
    assign sel_oh_next = state_nxt;

    a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(sel_oh));

endmodule

// File: rtl/s38417_slot_bank_seq.sv
// Slot-bank feeder for the s38417 compare cone: 3-slot register bank, rotating select,
// write-first registered word output, registered compare and saturating mismatch counter.
module s38417_slot_bank_seq
    import s38417_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int NSLOT = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_slot,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             advance,
    input  logic             exp_valid,
    input  logic [WIDTH-1:0] exp_vec,
    input  logic             cnt_clr,
    output logic [2:0]       sel_oh,
    output logic [WIDTH-1:0] sel_word,
    output logic             sel_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             wr_err
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [2:0]       sel_oh_next;
    logic [WIDTH-1:0] bank      [NSLOT];
    logic [WIDTH-1:0] bank_next [NSLOT];
    logic [WIDTH-1:0] word_mux;
    logic             wr_bad;

    s38417_onehot_rot u_rot (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
        .sel_oh      (sel_oh),
        .sel_oh_next (sel_oh_next)
    );

    assign wr_bad = wr_en && (slot_t'(wr_slot) == SLOT_BAD);

    // Stage p0: post-write bank image and AND-OR select against the post-edge select
    always_comb begin
        word_mux = '0;
        for (int i = 0; i < NSLOT; i++) begin
            bank_next[i] = bank[i];
            if (wr_en && (wr_slot == slot_t'(i))) begin
                bank_next[i] = wr_data;
            end
            word_mux = word_mux | (bank_next[i] & {WIDTH{sel_oh_next[i]}});
        end
    end

    // Stage p1: bank, selected word and valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                bank[i] <= '0;
            end
            sel_word  <= '0;
            sel_valid <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                bank[i] <= bank_next[i];
            end
            sel_word  <= word_mux;
            sel_valid <= 1'b1;
            if (wr_bad) begin
                wr_err <= 1'b1;
            end
        end
    end

    // Stage p2: compare of the registered word, then the counter one edge later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            mismatch <= exp_valid && sel_valid && (|(sel_word ^ exp_vec));
            if (cnt_clr) begin
                mismatch_cnt <= '0;
            end else if (mismatch) begin
                mismatch_cnt <= sat_inc(mismatch_cnt);
            end
        end
    end

endmodule

// File: tb/tb_s38417_slot_bank_seq.sv
// Directed bench for s38417_slot_bank_seq: reset, rotation, write+advance,
// compare, counter saturation/clear, illegal slot and mid-rotation reset.
module tb_s38417_slot_bank_seq;

    localparam int WIDTH = 10;
    localparam int NSLOT = 3;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [1:0]       wr_slot;
    logic [WIDTH-1:0] wr_data;
    logic             advance;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_vec;
    logic             cnt_clr;
    logic [2:0]       sel_oh;
    logic [WIDTH-1:0] sel_word;
    logic             sel_valid;
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             wr_err;

    int total;
    int bad;

    s38417_slot_bank_seq #(.WIDTH(WIDTH), .NSLOT(NSLOT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_slot      (wr_slot),
        .wr_data      (wr_data),
        .advance      (advance),
        .exp_valid    (exp_valid),
        .exp_vec      (exp_vec),
        .cnt_clr      (cnt_clr),
        .sel_oh       (sel_oh),
        .sel_word     (sel_word),
        .sel_valid    (sel_valid),
        .mismatch     (mismatch),
        .mismatch_cnt (mismatch_cnt),
        .wr_err       (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled and inputs re-driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++; if (sel_oh !== 3'b001) begin bad++; $display("FAIL reset_sel_oh: got %b want 001", sel_oh); end
        total++; if (sel_word !== 10'h000) begin bad++; $display("FAIL reset_sel_word: got %h want 000", sel_word); end
        total++; if (mismatch_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", mismatch_cnt); end
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
        total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL reset_sel_valid: got %b want 0", sel_valid); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
        rst_n = 1'b1;
        step();
        total++; if (sel_valid !== 1'b1) begin bad++; $display("FAIL release_sel_valid: got %b want 1", sel_valid); end
    endtask

    task automatic test_rotation();
        logic [WIDTH-1:0] exp_words [4];
        logic [2:0]       exp_sels  [4];
        exp_words[0] = 10'h2AA; exp_sels[0] = 3'b010;
        exp_words[1] = 10'h3FF; exp_sels[1] = 3'b100;
        exp_words[2] = 10'h155; exp_sels[2] = 3'b001;
        wr_en = 1'b1;
        wr_slot = 2'd0; wr_data = 10'h155; step();
        total++; if (sel_word !== 10'h155) begin bad++; $display("FAIL rot_write_first: got %h want 155", sel_word); end
        wr_slot = 2'd1; wr_data = 10'h2AA; step();
        wr_slot = 2'd2; wr_data = 10'h3FF; step();
        wr_en = 1'b0;
        total++; if (sel_oh !== 3'b001 || sel_word !== 10'h155) begin
            bad++; $display("FAIL rot_start: got sel_oh=%b word=%h want 001/155", sel_oh, sel_word);
        end
        advance = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (sel_oh !== exp_sels[i]) begin bad++; $display("FAIL rot_sel_oh[%0d]: got %b want %b", i, sel_oh, exp_sels[i]); end
            total++; if (sel_word !== exp_words[i]) begin bad++; $display("FAIL rot_sel_word[%0d]: got %h want %h", i, sel_word, exp_words[i]); end
        end
        advance = 1'b0;
        step();
        total++; if (sel_oh !== 3'b001 || sel_word !== 10'h155) begin
            bad++; $display("FAIL rot_hold: got sel_oh=%b word=%h want 001/155", sel_oh, sel_word);
        end
    endtask

    task automatic test_write_advance();
        advance = 1'b1; wr_en = 1'b1; wr_slot = 2'd1; wr_data = 10'h0F0;
        step();
        wr_en = 1'b0;
        total++; if (sel_oh !== 3'b010) begin bad++; $display("FAIL wa_sel_oh: got %b want 010", sel_oh); end
        total++; if (sel_word !== 10'h0F0) begin bad++; $display("FAIL wa_sel_word: got %h want 0F0", sel_word); end
        step();
        step();
        advance = 1'b0;
        total++; if (sel_oh !== 3'b001 || sel_word !== 10'h155) begin
            bad++; $display("FAIL wa_back_to_s0: got sel_oh=%b word=%h want 001/155", sel_oh, sel_word);
        end
    endtask

    task automatic test_compare();
        exp_valid = 1'b1; exp_vec = 10'h155;
        step();
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL cmp_equal: got %b want 0", mismatch); end
        exp_vec = 10'h154;
        step();
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL cmp_differ: got %b want 1", mismatch); end
        total++; if (mismatch_cnt !== 8'd0) begin bad++; $display("FAIL cmp_cnt_lag: got %0d want 0", mismatch_cnt); end
        exp_valid = 1'b0;
        step();
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL cmp_invalid: got %b want 0", mismatch); end
        total++; if (mismatch_cnt !== 8'd1) begin bad++; $display("FAIL cmp_cnt: got %0d want 1", mismatch_cnt); end
    endtask

    task automatic test_counter();
        // Count is 1 on entry; mismatch rises after the first edge, so after N edges cnt = N.
        exp_valid = 1'b1; exp_vec = 10'h154;
        for (int i = 0; i < 254; i++) step();
        total++; if (mismatch_cnt !== 8'd254) begin bad++; $display("FAIL cnt_254: got %0d want 254", mismatch_cnt); end
        step();
        total++; if (mismatch_cnt !== 8'd255) begin bad++; $display("FAIL cnt_255: got %0d want 255", mismatch_cnt); end
        for (int i = 0; i < 45; i++) step();
        total++; if (mismatch_cnt !== 8'd255) begin bad++; $display("FAIL cnt_saturate: got %0d want 255", mismatch_cnt); end
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL cnt_mismatch_held: got %b want 1", mismatch); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        total++; if (mismatch_cnt !== 8'd0) begin bad++; $display("FAIL cnt_clr_priority: got %0d want 0", mismatch_cnt); end
        step();
        total++; if (mismatch_cnt !== 8'd1) begin bad++; $display("FAIL cnt_resume: got %0d want 1", mismatch_cnt); end
        exp_valid = 1'b0;
        step();
        step();
        total++; if (mismatch_cnt !== 8'd2 || mismatch !== 1'b0) begin
            bad++; $display("FAIL cnt_idle: got cnt=%0d mm=%b want 2/0", mismatch_cnt, mismatch);
        end
    endtask

    task automatic test_bad_slot_and_reset();
        wr_en = 1'b1; wr_slot = 2'd3; wr_data = 10'h000;
        step();
        wr_en = 1'b0;
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL bad_wr_err: got %b want 1", wr_err); end
        total++; if (sel_word !== 10'h155) begin bad++; $display("FAIL bad_slot0: got %h want 155", sel_word); end
        advance = 1'b1;
        step();
        total++; if (sel_word !== 10'h0F0) begin bad++; $display("FAIL bad_slot1: got %h want 0F0", sel_word); end
        step();
        advance = 1'b0;
        total++; if (sel_oh !== 3'b100 || sel_word !== 10'h3FF) begin
            bad++; $display("FAIL bad_slot2: got sel_oh=%b word=%h want 100/3FF", sel_oh, sel_word);
        end
        total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL bad_wr_err_sticky: got %b want 1", wr_err); end
        rst_n = 1'b0; advance = 1'b1; wr_en = 1'b1; wr_slot = 2'd0; wr_data = 10'h0AB;
        step();
        total++; if (sel_oh !== 3'b001) begin bad++; $display("FAIL midrst_sel_oh: got %b want 001", sel_oh); end
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL midrst_wr_err: got %b want 0", wr_err); end
        total++; if (sel_word !== 10'h000 || sel_valid !== 1'b0 || mismatch_cnt !== 8'd0) begin
            bad++; $display("FAIL midrst_outputs: got word=%h vld=%b cnt=%0d want 000/0/0", sel_word, sel_valid, mismatch_cnt);
        end
        rst_n = 1'b1; advance = 1'b0; wr_en = 1'b0;
        step();
        total++; if (sel_word !== 10'h000 || sel_valid !== 1'b1 || sel_oh !== 3'b001) begin
            bad++; $display("FAIL midrst_release: got word=%h vld=%b sel_oh=%b want 000/1/001", sel_word, sel_valid, sel_oh);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_slot = 2'd0; wr_data = '0;
        advance = 1'b0; exp_valid = 1'b0; exp_vec = '0; cnt_clr = 1'b0;
        #1;
        test_reset();
        test_rotation();
        test_write_advance();
        test_compare();
        test_counter();
        test_bad_slot_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
